// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority-vote bit sampling, parity/framing checks,
// and a first-word-fall-through result FIFO with valid/ready pop and sticky overrun.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_50m,
  input  logic                             rst_n,
  input  logic                             clken,
  input  logic                             rx,
  input  logic                             parity_en,
  input  logic                             parity_odd,
  input  logic                             err_clr,
  output logic [DATA_BITS-1:0]             data,
  output logic                             frame_err,
  output logic                             parity_err,
  output logic                             valid,
  input  logic                             ready,
  output logic                             overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level
);

  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int WW  = DATA_BITS + 2;
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [SW-1:0] S_MIDM1 = SW'(MID - 1);
  localparam logic [SW-1:0] S_MID   = SW'(MID);
  localparam logic [SW-1:0] S_MIDP1 = SW'(MID + 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] L_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic                  r_rxMeta;
  logic                  r_rxS;
  logic                  r_armed;
  logic [SW-1:0]         r_sample;
  logic [1:0]            r_ones;
  logic [BW-1:0]         r_bitPos;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_parityErr;
  logic                  r_parEn;
  logic                  r_parOdd;
  logic                  w_vote;
  logic                  w_lastSample;
  logic                  w_push;
  logic                  w_frameErr;

  logic [WW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [LW-1:0]         r_level;
  logic                  r_overrun;
  logic [WW-1:0]         r_hold;
  logic [WW-1:0]         w_head;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_doPush;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_rxMeta <= 1'b1;
      r_rxS    <= 1'b1;
    end else begin
      r_rxMeta <= rx;
      r_rxS    <= r_rxMeta;
    end
  end

  // Third vote sample arrives live at MID+1; the first two are accumulated in r_ones.
  assign w_vote       = (r_ones + {1'b0, r_rxS}) >= 2'd2;
  assign w_lastSample = (r_sample == S_LAST);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_push      = 1'b0;
    w_frameErr  = 1'b0;
    if (clken) begin
      case (r_state)
        IDLE:   if (r_armed && !r_rxS) w_stateNext = START;
        START: begin
          // At MID only two samples exist; both high already decides the vote.
          if (r_sample == S_MID && r_ones[0] && r_rxS) w_stateNext = IDLE;
          else if (w_lastSample)                      w_stateNext = DATA;
        end
        DATA:   if (w_lastSample && r_bitPos == B_LAST)
                  w_stateNext = r_parEn ? PARITY : STOP;
        PARITY: if (w_lastSample) w_stateNext = STOP;
        STOP: begin
          if (r_sample == S_MIDP1) begin
            w_push      = 1'b1;
            w_frameErr  = !w_vote;
            w_stateNext = IDLE;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_armed     <= 1'b0;
      r_sample    <= '0;
      r_ones      <= '0;
      r_bitPos    <= '0;
      r_shift     <= '0;
      r_parityErr <= 1'b0;
      r_parEn     <= 1'b0;
      r_parOdd    <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_parEn     <= parity_en;
        r_parOdd    <= parity_odd;
        r_parityErr <= 1'b0;
        r_bitPos    <= '0;
        if (r_rxS) r_armed <= 1'b1;
      end
      if (w_push) r_armed <= !w_frameErr;
      if (clken) begin
        if (r_state == IDLE || w_lastSample || w_stateNext == IDLE) r_sample <= '0;
        else                                                        r_sample <= r_sample + 1'b1;
        if (r_sample == S_MIDM1)   r_ones <= {1'b0, r_rxS};
        else if (r_sample == S_MID) r_ones <= r_ones + {1'b0, r_rxS};
        if (r_state == DATA && r_sample == S_MIDP1) r_shift[r_bitPos] <= w_vote;
        if (r_state == DATA && w_lastSample) r_bitPos <= r_bitPos + 1'b1;
        if (r_state == PARITY && r_sample == S_MIDP1)
          r_parityErr <= w_vote != ((^r_shift) ^ r_parOdd);
      end
    end
  end

  assign w_full   = (r_level == L_FULL);
  assign valid    = (r_level != '0);
  assign w_pop    = valid && ready;
  assign w_doPush = w_push && (!w_full || w_pop);
  assign w_head   = r_mem[r_rdPtr];

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
      r_hold    <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= {w_frameErr, r_parityErr, r_shift};
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
      else if (err_clr)               r_overrun <= 1'b0;
      if (valid) r_hold <= w_head;
    end
  end

  assign {frame_err, parity_err, data} = valid ? w_head : r_hold;
  assign overrun = r_overrun;
  assign level   = r_level;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo: serial frames are generated from
// a bit-level description and compared against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  logic                 clk_50m = 1'b0;
  logic                 rst_n;
  logic                 clken = 1'b0;
  logic                 rx;
  logic                 parity_en;
  logic                 parity_odd;
  logic                 err_clr;
  logic                 ready;
  logic [DATA_BITS-1:0] data;
  logic                 frame_err;
  logic                 parity_err;
  logic                 valid;
  logic                 overrun;
  logic [LW-1:0]        level;

  int vectorCount = 0;
  int missCount   = 0;
  int tickDiv     = 0;

  logic [DATA_BITS+1:0] modelQ[$];
  bit                   modelOverrun;
  logic [DATA_BITS-1:0] lastPopped;

  uart_rx_fifo #(
    .DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .rx(rx),
    .parity_en(parity_en), .parity_odd(parity_odd), .err_clr(err_clr),
    .data(data), .frame_err(frame_err), .parity_err(parity_err),
    .valid(valid), .ready(ready), .overrun(overrun), .level(level)
  );

  always #10 clk_50m = ~clk_50m;

  // One oversample tick every fourth system clock.
  always @(negedge clk_50m) begin
    clken   <= (tickDiv == 3);
    tickDiv <= (tickDiv + 1) % 4;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitTicks(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      while (!clken) @(posedge clk_50m);
    end
    #1;
  endtask

  // Drives one complete frame and records the word the receiver must produce.
  task automatic applyStimulus(input logic [DATA_BITS-1:0] d, input bit parEn, input bit parOdd,
                               input bit parOk, input bit stopBit);
    logic p;
    p = parOdd ? ~^d : ^d;
    if (!parOk) p = ~p;
    parity_en  = parEn;
    parity_odd = parOdd;
    rx = 1'b0;
    waitTicks(OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      waitTicks(OVERSAMPLE);
    end
    if (parEn) begin
      rx = p;
      waitTicks(OVERSAMPLE);
    end
    rx = stopBit;
    waitTicks(OVERSAMPLE);
    rx = 1'b1;
    waitTicks(4);
    if (modelQ.size() < FIFO_DEPTH) modelQ.push_back({!stopBit, parEn && !parOk, d});
    else                            modelOverrun = 1'b1;
  endtask

  task automatic checkStatus(input string tag);
    @(negedge clk_50m);
    checkOutput({tag, ".level"},   32'(level),   32'(modelQ.size()));
    checkOutput({tag, ".valid"},   32'(valid),   32'(modelQ.size() != 0));
    checkOutput({tag, ".overrun"}, 32'(overrun), 32'(modelOverrun));
  endtask

  task automatic drainAll(input string tag);
    logic [DATA_BITS+1:0] w;
    int n;
    n = modelQ.size();
    for (int i = 0; i < n; i++) begin
      w = modelQ.pop_front();
      @(negedge clk_50m);
      checkOutput({tag, ".valid"},     32'(valid),      32'd1);
      checkOutput({tag, ".data"},      32'(data),       32'(w[DATA_BITS-1:0]));
      checkOutput({tag, ".parityErr"}, 32'(parity_err), 32'(w[DATA_BITS]));
      checkOutput({tag, ".frameErr"},  32'(frame_err),  32'(w[DATA_BITS+1]));
      lastPopped = w[DATA_BITS-1:0];
      ready = 1'b1;
      @(negedge clk_50m);
      ready = 1'b0;
    end
    @(negedge clk_50m);
    checkOutput({tag, ".emptyValid"}, 32'(valid), 32'd0);
    checkOutput({tag, ".emptyLevel"}, 32'(level), 32'd0);
    if (n != 0) checkOutput({tag, ".holdData"}, 32'(data), 32'(lastPopped));
  endtask

  task automatic clearOverrun();
    @(negedge clk_50m);
    err_clr = 1'b1;
    @(negedge clk_50m);
    err_clr = 1'b0;
    modelOverrun = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    err_clr = 1'b0; ready = 1'b0; modelOverrun = 1'b0; lastPopped = '0;
    repeat (3) @(negedge clk_50m);
    checkOutput("reset.valid",   32'(valid),   32'd0);
    checkOutput("reset.level",   32'(level),   32'd0);
    checkOutput("reset.overrun", 32'(overrun), 32'd0);
    checkOutput("reset.data",    32'(data),    32'd0);
    checkOutput("reset.flags",   32'({frame_err, parity_err}), 32'd0);
    rst_n = 1'b1;
    waitTicks(4);

    $display("[TB] basic 8N1 frame");
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    checkStatus("basic");
    drainAll("basic");

    $display("[TB] even parity wrong then right");
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    checkStatus("parity");
    drainAll("parity");

    $display("[TB] break condition");
    parity_en = 1'b0;
    rx = 1'b0;
    waitTicks(12 * OVERSAMPLE);
    modelQ.push_back({1'b1, 1'b0, {DATA_BITS{1'b0}}});
    checkStatus("breakLow");
    rx = 1'b1;
    waitTicks(4);
    checkStatus("breakHigh");
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    checkStatus("afterBreak");
    drainAll("afterBreak");

    $display("[TB] false start");
    rx = 1'b0;
    waitTicks(4);
    rx = 1'b1;
    waitTicks(40);
    checkStatus("falseStart");
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
    drainAll("afterFalse");

    $display("[TB] overflow and overrun clear");
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i * 8'h11), 1'b0, 1'b0, 1'b1, 1'b1);
    checkStatus("overflow");
    drainAll("overflow");
    clearOverrun();
    checkStatus("errClr");
    @(negedge clk_50m);
    ready = 1'b1;
    @(negedge clk_50m);
    ready = 1'b0;
    checkStatus("idleReady");

    $display("[TB] reset mid-frame");
    parity_en = 1'b0;
    rx = 1'b0;
    waitTicks(OVERSAMPLE);
    rx = 1'b1;
    waitTicks(OVERSAMPLE);
    rx = 1'b0;
    waitTicks(10);
    @(negedge clk_50m);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    modelQ.delete();
    modelOverrun = 1'b0;
    waitTicks(4);
    checkStatus("resetMid");
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    checkStatus("afterReset");
    drainAll("afterReset");

    $display("[TB] random bursts");
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++)
        applyStimulus(8'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom % 4) != 0, ($urandom % 5) != 0);
      checkStatus("random");
      drainAll("random");
      if (modelOverrun) begin
        clearOverrun();
        checkStatus("randomClr");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
